acq_capture_ctrl: RTL

//  Parametrised successor of the scope acquisition state machine. Replaces the pre/post FIFO pair with one ring buffer.

---
 rtl/acq_capture_ctrl_pkg.sv | 22 ++
 rtl/acq_ring_buffer.sv | 36 +++
 rtl/acq_capture_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/acq_capture_ctrl_pkg.sv
// Shared state codes, trigger-mode codes and default geometry for the acquisition controller.
package acq_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_READ  = 3'd3,
    ST_HOLD  = 3'd4
  } acq_state_e;

  // Modes 0 and 3 both behave as normal edge triggering.
  localparam logic [1:0] TM_AUTO   = 2'd1;
  localparam logic [1:0] TM_SINGLE = 2'd2;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_SAMPLE_W = 14;
  localparam int DEF_DEPTH    = 512;
  localparam int DEF_AW       = 9;
  localparam int DEF_TO_W     = 24;

endpackage

// File: rtl/acq_ring_buffer.sv
// Record storage: simple dual-port RAM, one write port and one registered read port.
// Read data appears the cycle after re and holds until the next re.
module acq_ring_buffer #(
  parameter int DW = 28,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/acq_capture_ctrl.sv
// Scope acquisition: ring-buffer capture around a trigger, then DEPTH-sample readout.
// First rd_valid one cycle after READ entry, then one sample per clk; rd_* hold while rd_ready is low.
module acq_capture_ctrl
  import acq_capture_ctrl_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int TO_W     = DEF_TO_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_en,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
  input  logic                       trig_in,
  input  logic                       force_trig,
  input  logic [1:0]                 trig_mode,
  input  logic [AW-1:0]              pre_len,
  input  logic [TO_W-1:0]            auto_timeout,
  input  logic                       rearm,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [NUM_CH*SAMPLE_W-1:0] rd_data,
  output logic [AW-1:0]              rd_index,
  output logic                       rd_last,
  output logic [2:0]                 acq_state,
  output logic                       trig_forced,
  output logic                       ss_waiting
);

  localparam int DW = NUM_CH * SAMPLE_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);

  acq_state_e      state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   trig_ptr_q, trig_ptr_d;
  logic [AW-1:0]   pre_q, pre_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW:0]     iss_q, iss_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            trig_prev_q, trig_prev_d;
  logic            trig_forced_q, trig_forced_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic [AW-1:0]   rd_index_q, rd_index_d;

  logic            we, re, edge_det, auto_fire, trig_fire;
  logic [AW-1:0]   rd_addr;
  logic [AW:0]     post_target;

  // pre_len is AW bits wide, so it can never exceed DEPTH-1 and needs no clamp.
  assign post_target = DEPTH_C - {1'b0, pre_q};
  assign edge_det    = sample_en & trig_in & ~trig_prev_q;
  assign auto_fire   = (trig_mode == TM_AUTO) & (to_cnt_q >= auto_timeout) & sample_en;
  assign trig_fire   = edge_det | force_trig | auto_fire;
  assign rd_addr     = trig_ptr_q - pre_q + iss_q[AW-1:0];

  always_comb begin
    state_d       = state_q;
    trig_ptr_d    = trig_ptr_q;
    pre_d         = pre_q;
    cnt_d         = cnt_q;
    iss_d         = iss_q;
    to_cnt_d      = to_cnt_q;
    trig_forced_d = trig_forced_q;
    rd_valid_d    = rd_valid_q;
    rd_last_d     = rd_last_q;
    rd_index_d    = rd_index_q;
    we            = 1'b0;
    re            = 1'b0;
    trig_prev_d   = sample_en ? trig_in : trig_prev_q;

    unique case (state_q)
      ST_FILL: begin
        we = sample_en;
        if (cnt_q == {1'b0, pre_q}) begin
          state_d  = ST_ARMED;
          to_cnt_d = '0;
        end else if (sample_en) begin
          cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
        end
      end
      ST_ARMED: begin
        we = sample_en;
        if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (trig_fire) begin
          // Trigger sample lands at wr_ptr whether written now or on the next strobe.
          state_d       = ST_POST;
          trig_ptr_d    = wr_ptr_q;
          trig_forced_d = ~edge_det;
          cnt_d         = {{AW{1'b0}}, sample_en};
        end
      end
      ST_POST: begin
        // Never write past the target, or the oldest pre-trigger sample is lost.
        we    = sample_en & (cnt_q < post_target);
        cnt_d = cnt_q + {{AW{1'b0}}, we};
        if (cnt_d == post_target) begin
          state_d    = ST_READ;
          iss_d      = '0;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
      end
      ST_READ: begin
        if ((iss_q < DEPTH_C) && (!rd_valid_q || rd_ready)) begin
          re         = 1'b1;
          rd_valid_d = 1'b1;
          rd_index_d = iss_q[AW-1:0];
          rd_last_d  = (iss_q == LAST_C);
          iss_d      = iss_q + {{AW{1'b0}}, 1'b1};
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
        if (rd_valid_q && rd_ready && rd_last_q) begin
          if (trig_mode == TM_SINGLE) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_FILL;
            cnt_d   = '0;
            pre_d   = pre_len;
          end
        end
      end
      ST_HOLD: begin
        if (rearm) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          pre_d   = pre_len;
        end
      end
      default: state_d = ST_FILL;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(we);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_FILL;
      wr_ptr_q      <= '0;
      trig_ptr_q    <= '0;
      pre_q         <= pre_len;
      cnt_q         <= '0;
      iss_q         <= '0;
      to_cnt_q      <= '0;
      trig_prev_q   <= 1'b0;
      trig_forced_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_index_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      trig_ptr_q    <= trig_ptr_d;
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      iss_q         <= iss_d;
      to_cnt_q      <= to_cnt_d;
      trig_prev_q   <= trig_prev_d;
      trig_forced_q <= trig_forced_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      rd_index_q    <= rd_index_d;
    end
  end

  acq_ring_buffer #(
    .DW (DW),
    .AW (AW)
  ) u_ring (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (wr_ptr_q),
    .wdata   (sample_in),
    .re      (re),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

  assign rd_valid    = rd_valid_q;
  assign rd_index    = rd_index_q;
  assign rd_last     = rd_last_q;
  assign acq_state   = state_q;
  assign trig_forced = trig_forced_q;
  assign ss_waiting  = (state_q == ST_HOLD);

endmodule
